// File: rtl/tra.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tra : fixed-time traffic-light controller for one intersection approach.   |
// | Revision 1.0                                                              |
// +----------------------------------------------------------------------------+
module tra #(
  parameter int MODE     = 0,
  parameter int GREEN_T  = 20,
  parameter int YELLOW_T = 5,
  parameter int ALLRED_T = 2,
  parameter int FLASH_T  = 5,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] car_light,
  output logic [1:0] hmn_light
);

  localparam int H = GREEN_T + YELLOW_T + ALLRED_T;
  localparam int P = 2 * H;

  localparam logic [CW:0] c_half     = (CW+1)'(H);
  localparam logic [CW:0] c_period   = (CW+1)'(P);
  localparam logic [CW:0] c_last     = (CW+1)'(P - 1);
  localparam logic [CW:0] c_green    = (CW+1)'(GREEN_T);
  localparam logic [CW:0] c_yel_end  = (CW+1)'(GREEN_T + YELLOW_T);
  localparam logic [CW:0] c_walk_end = (CW+1)'(GREEN_T - FLASH_T);

  localparam logic [1:0] c_car_red    = 2'b00;
  localparam logic [1:0] c_car_yellow = 2'b01;
  localparam logic [1:0] c_car_green  = 2'b10;
  localparam logic [1:0] c_hmn_stop   = 2'b00;
  localparam logic [1:0] c_hmn_flash  = 2'b01;
  localparam logic [1:0] c_hmn_walk   = 2'b10;

  // The out-of-phase instance begins its half-period in red.
  localparam logic [1:0] c_car_rst = (MODE == 0) ? c_car_green : c_car_red;
  localparam logic [1:0] c_hmn_rst = (MODE == 0) ? c_hmn_walk  : c_hmn_stop;

  if (GREEN_T < 1 || YELLOW_T < 1 || ALLRED_T < 1) begin : g_bad_durations
    $error("tra: GREEN_T, YELLOW_T and ALLRED_T must all be at least 1");
  end
  if (FLASH_T < 0 || FLASH_T >= GREEN_T) begin : g_bad_flash
    $error("tra: FLASH_T must lie in 0..GREEN_T-1");
  end
  if (P > (1 << CW)) begin : g_bad_width
    $error("tra: full period does not fit in CW bits");
  end

  logic [CW-1:0] cycle;
  logic [CW-1:0] cycle_d;
  logic [CW:0]   w_next_ext;
  logic [CW:0]   w_sum;
  logic [CW:0]   w_phase;
  logic [1:0]    car_d;
  logic [1:0]    hmn_d;

  // Outputs decode the value cycle is about to take, so they never lag it.
  always_comb begin
    cycle_d    = '0;
    w_next_ext = '0;
    w_sum      = '0;
    w_phase    = '0;
    car_d      = c_car_red;
    hmn_d      = c_hmn_stop;

    if ({1'b0, cycle} < c_last) begin
      cycle_d = cycle + 1'b1;
    end

    w_next_ext = {1'b0, cycle_d};
    w_sum      = w_next_ext + c_half;
    if (MODE != 0) begin
      w_phase = (w_sum >= c_period) ? (w_sum - c_period) : w_sum;
    end else begin
      w_phase = w_next_ext;
    end

    if (w_phase < c_green) begin
      car_d = c_car_green;
    end else if (w_phase < c_yel_end) begin
      car_d = c_car_yellow;
    end

    if (w_phase < c_walk_end) begin
      hmn_d = c_hmn_walk;
    end else if (w_phase < c_green) begin
      hmn_d = c_hmn_flash;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cycle     <= '0;
      car_light <= c_car_rst;
      hmn_light <= c_hmn_rst;
    end else begin
      cycle     <= cycle_d;
      car_light <= car_d;
      hmn_light <= hmn_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tra.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tra : scoreboard bench for an NS/EW controller pair and a short variant.|
// | Revision 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_tra;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] ns_car, ns_hmn, ew_car, ew_hmn, v_car, v_hmn;

  always #5 clk = ~clk;

  tra #(.MODE(0)) dut_ns (.clk(clk), .rst_n(rst_n), .car_light(ns_car), .hmn_light(ns_hmn));
  tra #(.MODE(1)) dut_ew (.clk(clk), .rst_n(rst_n), .car_light(ew_car), .hmn_light(ew_hmn));
  tra #(.MODE(0), .GREEN_T(3), .YELLOW_T(1), .ALLRED_T(1), .FLASH_T(1)) dut_v (
    .clk(clk), .rst_n(rst_n), .car_light(v_car), .hmn_light(v_hmn));

  typedef struct packed {
    logic [7:0] ns_cyc;
    logic [1:0] ns_car;
    logic [1:0] ns_hmn;
    logic [7:0] ew_cyc;
    logic [1:0] ew_car;
    logic [1:0] ew_hmn;
    logic [7:0] v_cyc;
    logic [1:0] v_car;
    logic [1:0] v_hmn;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_cyc = 0;
  int   m_vcyc = 0;

  // Reference timings written directly from the defaults' cycle table.
  function automatic logic [1:0] ns_car_of(input int c);
    if (c <= 19) return 2'b10;
    if (c <= 24) return 2'b01;
    return 2'b00;
  endfunction
  function automatic logic [1:0] ns_hmn_of(input int c);
    if (c <= 14) return 2'b10;
    if (c <= 19) return 2'b01;
    return 2'b00;
  endfunction
  function automatic logic [1:0] ew_car_of(input int c);
    if (c >= 27 && c <= 46) return 2'b10;
    if (c >= 47 && c <= 51) return 2'b01;
    return 2'b00;
  endfunction
  function automatic logic [1:0] ew_hmn_of(input int c);
    if (c >= 27 && c <= 41) return 2'b10;
    if (c >= 42 && c <= 46) return 2'b01;
    return 2'b00;
  endfunction
  function automatic logic [1:0] v_car_of(input int c);
    if (c <= 2) return 2'b10;
    if (c == 3) return 2'b01;
    return 2'b00;
  endfunction
  function automatic logic [1:0] v_hmn_of(input int c);
    if (c <= 1) return 2'b10;
    if (c == 2) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Drive one clock of stimulus, predict the post-edge state, then compare.
  task automatic step(input logic rst);
    exp_t e;
    rst_n = rst;
    if (rst) begin
      m_cyc  = 0;
      m_vcyc = 0;
    end else begin
      m_cyc  = (m_cyc == 53) ? 0 : m_cyc + 1;
      m_vcyc = (m_vcyc == 9) ? 0 : m_vcyc + 1;
    end
    e.ns_cyc = 8'(m_cyc);
    e.ns_car = ns_car_of(m_cyc);
    e.ns_hmn = ns_hmn_of(m_cyc);
    e.ew_cyc = 8'(m_cyc);
    e.ew_car = ew_car_of(m_cyc);
    e.ew_hmn = ew_hmn_of(m_cyc);
    e.v_cyc  = 8'(m_vcyc);
    e.v_car  = v_car_of(m_vcyc);
    e.v_hmn  = v_hmn_of(m_vcyc);
    q.push_back(e);

    @(posedge clk);
    #1;
    e = q.pop_front();
    check("ns_cycle", dut_ns.cycle, e.ns_cyc);
    check("ns_car",   {6'd0, ns_car}, {6'd0, e.ns_car});
    check("ns_hmn",   {6'd0, ns_hmn}, {6'd0, e.ns_hmn});
    check("ew_cycle", dut_ew.cycle, e.ew_cyc);
    check("ew_car",   {6'd0, ew_car}, {6'd0, e.ew_car});
    check("ew_hmn",   {6'd0, ew_hmn}, {6'd0, e.ew_hmn});
    check("v_cycle",  dut_v.cycle, e.v_cyc);
    check("v_car",    {6'd0, v_car}, {6'd0, e.v_car});
    check("v_hmn",    {6'd0, v_hmn}, {6'd0, e.v_hmn});
    check("conflict", {7'd0, (ns_car != 2'b00) && (ew_car != 2'b00)}, 8'd0);
  endtask

  initial begin
    // Reset hold for two clocks.
    step(1'b1);
    step(1'b1);

    // Three full default periods.
    for (int i = 0; i < 162; i++) step(1'b0);

    // Advance to cycle 33, then reset for a single clock mid-period.
    for (int i = 0; i < 33; i++) step(1'b0);
    step(1'b1);

    // The sequence must restart identically, including the 53 -> 0 wrap.
    for (int i = 0; i < 60; i++) step(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tra.md
Name: tra

Overview:
- Fixed-time traffic-light controller for one approach of a two-way intersection.
- Drives a vehicle signal and a pedestrian signal from a free-running cycle counter.
- Two instances share clk and rst_n: MODE=0 for north-south, MODE=1 for east-west. The EW instance runs half a period out of phase, so the pair forms a complete, conflict-free intersection.
- Internal counter `cycle` is a named register so benches can probe it hierarchically (inst.cycle).

Parameters:
- MODE, 0: phase select. 0 = starts in green at reset. Any nonzero value = offset by half a period (starts in red).
- GREEN_T, 20: vehicle green duration, clocks (≥1).
- YELLOW_T, 5: vehicle yellow duration, clocks (≥1).
- ALLRED_T, 2: all-red clearance at the end of each half-period, clocks (≥1).
- FLASH_T, 5: pedestrian flashing duration at the end of green, clocks (0..GREEN_T-1).
- CW, 8: width of `cycle`. Must satisfy 2*H ≤ 2^CW.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-high reset. Despite the codebase's `_n` port name, rst_n=1 resets.
- car_light  output  2  vehicle signal: 2'b00 red, 2'b01 yellow, 2'b10 green. 2'b11 never driven.
- hmn_light  output  2  pedestrian signal: 2'b00 don't-walk, 2'b01 flashing (clear), 2'b10 walk. 2'b11 never driven.

Behaviour:
- Derived constants: H = GREEN_T + YELLOW_T + ALLRED_T (half-period); P = 2*H (full period). Defaults: H=27, P=54.
- `cycle` (CW bits, register):
  - Reset: rst_n=1 at a rising edge → cycle=0.
  - Otherwise: cycle = (cycle==P-1) ? 0 : cycle+1. Wraps at P-1 → 0.
  - No enable input; the counter never stalls.
- Phase: p = MODE ? (cycle+H ≥ P ? cycle+H-P : cycle+H) : cycle, range 0..P-1. Compute in CW+1 bits; no overflow.
- Vehicle decode, by p:
  - 0 ≤ p < GREEN_T → green.
  - GREEN_T ≤ p < GREEN_T+YELLOW_T → yellow.
  - Otherwise → red. This covers the all-red gap and the entire second half-period.
- Pedestrian decode, by p:
  - 0 ≤ p < GREEN_T-FLASH_T → walk.
  - GREEN_T-FLASH_T ≤ p < GREEN_T → flashing.
  - Otherwise → don't-walk.
  - Pedestrians are never in walk or flashing while car_light is yellow or red.
- Output timing:
  - car_light and hmn_light are registered. On every edge, each loads the decode of the value `cycle` takes at that same edge.
  - Hence in every clock, the outputs equal decode(cycle). Zero lag vs `cycle`; no glitches.
- Reset values:
  - MODE=0: cycle=0, car_light=2'b10, hmn_light=2'b10.
  - MODE≠0: cycle=0, car_light=2'b00, hmn_light=2'b00.
- Reset asserted mid-period: the next edge forces the reset values, regardless of the current phase. Counting resumes from 0 on the first edge with rst_n=0.
- Pairing invariant, for MODE 0/1 instances with the same parameters and a common reset: at least one car_light is red in every clock. With ALLRED_T ≥ 1, both are red for ALLRED_T clocks before each green handover.
- Parameter legality is a static check (generate-time $error): GREEN_T/YELLOW_T/ALLRED_T ≥ 1, FLASH_T < GREEN_T, P ≤ 2^CW.
- Out-of-range `cycle` values cannot occur after reset. If ever ≥ P, the next value is 0.

Test Plan:
- Reset hold: rst_n=1 for 2 clocks, both instances → cycle=0. NS car=10, hmn=10. EW car=00, hmn=00.
- NS sequence after release (defaults):
  - cycle 0–14: car=10, hmn=10.
  - cycle 15–19: car=10, hmn=01.
  - cycle 20–24: car=01, hmn=00.
  - cycle 25–53: car=00, hmn=00.
  - cycle 53 → 0: returns to car=10.
- EW sequence: cycle 27–46 car=10; 47–51 car=01; 52–53 and 0–26 car=00.
- Conflict check: over 3 full periods (162 clocks), assert never (ns_car≠00 && ew_car≠00). Both are 00 at cycles 25–26 and 52–53.
- Mid-period reset: assert rst_n=1 at cycle 33 for 1 clock → NS car=10 and EW car=00 on the next clock, cycle=0. Sequence restarts identically.
- Parameter variant: GREEN_T=3, YELLOW_T=1, ALLRED_T=1, FLASH_T=1 → P=10. NS car: 10,10,10,01,00 ×6 repeating. NS hmn: 10,10,01,00…. `cycle` wraps 9→0.
